// File: rtl/regfile_mp_async_rstn_if.sv
// Register file access bundle: clear, read ports and write ports.
// The register file takes the slave side; the issue/writeback logic drives master.
interface regfile_mp_async_rstn_if #(
  parameter int WIDTH    = 32,
  parameter int N_RPORTS = 2,
  parameter int N_WPORTS = 1,
  parameter int AW       = 5
);
  logic                               clr;
  logic [N_RPORTS-1:0][AW-1:0]        raddr;
  logic [N_RPORTS-1:0][WIDTH-1:0]     rdata;
  logic [N_WPORTS-1:0][AW-1:0]        waddr;
  logic [N_WPORTS-1:0]                wen;
  logic [N_WPORTS-1:0][WIDTH-1:0]     wdata;

  modport master (
    output clr, raddr, waddr, wen, wdata,
    input  rdata
  );

  modport slave (
    input  clr, raddr, waddr, wen, wdata,
    output rdata
  );
endinterface

// File: rtl/regfile_mp_async_rstn.sv
// Multi-port register file: prioritised writes, optional bypass,
// optional registered reads, hardwired-zero entry 0 and bulk clear.
module regfile_mp_async_rstn #(
  parameter int               WIDTH     = 32,
  parameter int               N_REG     = 32,
  parameter int               N_RPORTS  = 2,
  parameter int               N_WPORTS  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ZERO_REG  = 1'b0,
  parameter bit               BYPASS    = 1'b0,
  parameter bit               RD_REG    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstn,
  regfile_mp_async_rstn_if.slave  rf
);

  localparam int AW = (N_REG > 2) ? $clog2(N_REG) : 1;

  logic [WIDTH-1:0] mem [N_REG];

  for (genvar k = 0; k < N_REG; k++) begin : g_ent
    if (ZERO_REG && k == 0) begin : g_zero
      assign mem[k] = '0;
    end else begin : g_flop
      logic             we;
      logic [WIDTH-1:0] wd;
      logic [WIDTH-1:0] q;

      // Ascending scan: the highest-index hitting port wins.
      always_comb begin
        we = 1'b0;
        wd = '0;
        for (int p = 0; p < N_WPORTS; p++) begin
          if (rf.wen[p] && rf.waddr[p] == AW'(k)) begin
            we = 1'b1;
            wd = rf.wdata[p];
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          q <= RESET_VAL;
        end else if (rf.clr) begin
          q <= RESET_VAL;
        end else if (we) begin
          q <= wd;
        end
      end

      assign mem[k] = q;
    end
  end

  for (genvar r = 0; r < N_RPORTS; r++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] val;

    assign a = rf.raddr[r];

    always_comb begin
      val = '0;
      if (int'(a) < N_REG && !(ZERO_REG && a == '0)) begin
        val = mem[a];
        if (BYPASS && !rf.clr) begin
          for (int p = 0; p < N_WPORTS; p++) begin
            if (rf.wen[p] && rf.waddr[p] == a) begin
              val = rf.wdata[p];
            end
          end
        end
      end
    end

    if (RD_REG) begin : g_reg
      logic [WIDTH-1:0] q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          q <= '0;
        end else if (rf.clr) begin
          q <= '0;
        end else begin
          q <= val;
        end
      end

      assign rf.rdata[r] = q;
    end else begin : g_comb
      assign rf.rdata[r] = val;
    end
  end

endmodule
